sweep_gen: RTL and testbench



---
 rtl/gen_pkg.sv | 14 +
 rtl/sweep_dwell_timer.sv | 29 ++
 rtl/sweep_gen.sv | 126 ++++++++++++
 tb/tb_sweep_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gen_pkg.sv
// Shared definitions for the signal-generation path (communication, sweep_gen, dds).
package gen_pkg;

  localparam int unsigned TW_WIDTH    = 32;
  localparam int unsigned DWELL_WIDTH = 24;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StDwell,
    StDone
  } state_e;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable dwell down-counter; expire is high once the count has reached zero.
module sweep_dwell_timer
  import gen_pkg::*;
#(
  parameter int unsigned DW = DWELL_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] dwell,
  output logic          expire
);

  logic [DW-1:0] cnt_q;

  // A dwell of zero behaves like one: the loaded count is max(dwell,1)-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (dwell == '0) ? '0 : dwell - DW'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DW'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/sweep_gen.sv
// Frequency-sweep sequencer: steps the dds tuning word from f_start to f_stop,
// strobing set for each point and holding it for the programmed dwell.
module sweep_gen
  import gen_pkg::*;
#(
  parameter int unsigned W  = TW_WIDTH,
  parameter int unsigned DW = DWELL_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          repeat_mode,
  input  logic [W-1:0]  f_start,
  input  logic [W-1:0]  f_stop,
  input  logic [W-1:0]  f_step,
  input  logic [DW-1:0] dwell,
  output logic [W-1:0]  m,
  output logic          set,
  output logic          en,
  output logic          busy,
  output logic          done
);

  state_e        state_q;
  logic [W-1:0]  start_q, stop_q, step_q;
  logic [DW-1:0] dwell_q;
  logic          rep_q, up_q;
  logic [W:0]    sum, diff;
  logic [W-1:0]  next_pt;
  logic          expire;

  sweep_dwell_timer #(
    .DW (DW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state_q == StEmit),
    .dwell  (dwell_q),
    .expire (expire)
  );

  // Carry/borrow and overshoot both clamp to f_stop; a zero step jumps straight there.
  always_comb begin
    sum     = {1'b0, m} + {1'b0, step_q};
    diff    = {1'b0, m} - {1'b0, step_q};
    next_pt = stop_q;
    if (step_q != '0) begin
      if (up_q) begin
        if (!sum[W] && (sum[W-1:0] < stop_q)) next_pt = sum[W-1:0];
      end else begin
        if (!diff[W] && (diff[W-1:0] > stop_q)) next_pt = diff[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      rep_q   <= 1'b0;
      up_q    <= 1'b0;
      m       <= '0;
      set     <= 1'b0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort) begin
      state_q <= StIdle;
      set     <= 1'b0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            start_q <= f_start;
            stop_q  <= f_stop;
            step_q  <= f_step;
            dwell_q <= dwell;
            rep_q   <= repeat_mode;
            up_q    <= (f_stop >= f_start);
            m       <= f_start;
            set     <= 1'b1;
            en      <= 1'b1;
            busy    <= 1'b1;
            state_q <= StEmit;
          end
        end
        StEmit: begin
          set     <= 1'b0;
          state_q <= StDwell;
        end
        StDwell: begin
          if (expire) begin
            if (m == stop_q) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              m       <= next_pt;
              set     <= 1'b1;
              state_q <= StEmit;
            end
          end
        end
        StDone: begin
          done <= 1'b0;
          if (rep_q) begin
            m       <= start_q;
            set     <= 1'b1;
            state_q <= StEmit;
          end else begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_gen.sv
// Scoreboard bench for sweep_gen: stimulus pushes expected set/done events,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_sweep_gen;

  localparam int unsigned W  = 32;
  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          rst, start, abort, repeat_mode;
  logic [W-1:0]  f_start, f_stop, f_step;
  logic [DW-1:0] dwell;
  logic [W-1:0]  m;
  logic          set, en, busy, done;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           is_done;
    logic [W-1:0] m;
    int           cyc;
  } exp_t;

  exp_t q[$];

  sweep_gen #(
    .W  (W),
    .DW (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .repeat_mode (repeat_mode),
    .f_start     (f_start),
    .f_stop      (f_stop),
    .f_step      (f_step),
    .dwell       (dwell),
    .m           (m),
    .set         (set),
    .en          (en),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (set || done)) begin
      checks++;
      if (set && done) begin
        errors++;
        $display("FAIL set_done_overlap: set=%0b done=%0b at cyc %0d, required not both", set,
                 done, cyc);
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: set=%0b done=%0b m=0x%0h at cyc %0d, none expected",
                 set, done, m, cyc);
      end else begin
        e = q.pop_front();
        if ((e.is_done != done) || (!done && (m !== e.m)) || (cyc != e.cyc)) begin
          errors++;
          $display("FAIL scoreboard: got done=%0b m=0x%0h cyc=%0d, expected done=%0b m=0x%0h cyc=%0d",
                   done, m, cyc, e.is_done, e.m, e.cyc);
        end
      end
    end
  end

  function automatic void exp_set(input logic [W-1:0] mv, input int c);
    exp_t e;
    e.is_done = 1'b0;
    e.m       = mv;
    e.cyc     = c;
    q.push_back(e);
  endfunction

  function automatic void exp_done(input int c);
    exp_t e;
    e.is_done = 1'b1;
    e.m       = '0;
    e.cyc     = c;
    q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic launch(input logic [W-1:0] fs, input logic [W-1:0] fe, input logic [W-1:0] st,
                        input logic [DW-1:0] dw, input logic rep, output int c);
    @(negedge clk);
    f_start     = fs;
    f_stop      = fe;
    f_step      = st;
    dwell       = dw;
    repeat_mode = rep;
    start       = 1'b1;
    c           = cyc;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d events still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; abort = 1'b0; repeat_mode = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_m", m, '0);
      chk("idle_ctl", W'({set, en, busy, done}), '0);
    end

    // Up sweep, dwell 3; a stray start mid-sweep must not disturb it.
    launch(100, 130, 10, 3, 1'b0, c);
    exp_set(100, c + 1); exp_set(110, c + 5); exp_set(120, c + 9); exp_set(130, c + 13);
    exp_done(c + 17);
    release_start();
    goto_cyc(c + 6);
    start = 1'b1; f_start = 999; f_stop = 0; f_step = 1; dwell = 0;
    @(negedge clk);
    start = 1'b0;
    goto_cyc(c + 18);
    chk("up_busy_after", W'(busy), 0);
    chk("up_en_after", W'(en), 1);
    chk("up_m_held", m, 130);
    chk("up_done_after", W'(done), 0);
    drain(5);

    // Abort while idle drops en and keeps m.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("idle_abort_en", W'(en), 0);
    chk("idle_abort_m", m, 130);

    // Down sweep with overshoot clamp, dwell 0.
    launch(50, 20, 12, 0, 1'b0, c);
    exp_set(50, c + 1); exp_set(38, c + 3); exp_set(26, c + 5); exp_set(20, c + 7);
    exp_done(c + 9);
    release_start();
    drain(30);

    // Carry out of the top must clamp, not wrap.
    launch(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 2, 1'b0, c);
    exp_set(32'hFFFF_FFF0, c + 1); exp_set(32'hFFFF_FFFF, c + 4);
    exp_done(c + 7);
    release_start();
    drain(30);

    // Single point.
    launch(77, 77, 5, 0, 1'b0, c);
    exp_set(77, c + 1);
    exp_done(c + 3);
    release_start();
    drain(30);

    // Repeat mode, aborted mid-dwell of the third pass's first point.
    launch(5, 6, 1, 1, 1'b1, c);
    exp_set(5, c + 1); exp_set(6, c + 3); exp_done(c + 5);
    exp_set(5, c + 6); exp_set(6, c + 8); exp_done(c + 10);
    exp_set(5, c + 11);
    release_start();
    for (int t = c + 1; t <= c + 12; t++) begin
      goto_cyc(t);
      chk("rep_busy", W'(busy), 1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("rep_abort_busy", W'(busy), 0);
    chk("rep_abort_en", W'(en), 0);
    chk("rep_abort_set", W'(set), 0);
    chk("rep_abort_m", m, 5);
    repeat (6) @(negedge clk);
    drain(1);

    // Start and abort together from idle: abort wins.
    @(negedge clk);
    f_start = 1; f_stop = 2; f_step = 1; dwell = 0; repeat_mode = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", W'(busy), 0);
    chk("sa_set", W'(set), 0);
    repeat (6) @(negedge clk);
    chk("sa_busy_later", W'(busy), 0);

    // Reset mid-sweep.
    launch(100, 130, 10, 3, 1'b0, c);
    exp_set(100, c + 1);
    release_start();
    goto_cyc(c + 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_m", m, '0);
    chk("rst_mid_ctl", W'({set, en, busy, done}), '0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
